// File: rtl/memory_reader_if.sv
// ============================================================================
// Module      : memory_reader_if
// Description : Valid/ready stream carrying image words out of memory_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface memory_reader_if #(
    parameter int DATA_W = 18
) ();
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/memory_reader.sv
// ============================================================================
// Module      : memory_reader
// Description : Sweeps an address range in image bank A or B and streams the
//               words out through a 2-entry skid FIFO with credit-based issue.
//               Optional macro MEMORY_READER_STRIDE_EN adds a stride port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_reader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 18,
    parameter int LEN_W  = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic              bank_sel,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [LEN_W-1:0]  length,
`ifdef MEMORY_READER_STRIDE_EN
    input  wire logic [ADDR_W-1:0] stride,
`endif
    output logic      [ADDR_W-1:0] read_addr_a,
    input  wire logic [DATA_W-1:0] read_data_a,
    output logic      [ADDR_W-1:0] read_addr_b,
    input  wire logic [DATA_W-1:0] read_data_b,
    memory_reader_if.master        strm,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_bank;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_busy;
    logic              r_done;

    // FIFO entries carry {last, data}
    logic [DATA_W:0]   r_head;
    logic [DATA_W:0]   r_tail;
    logic              r_head_vld;
    logic              r_tail_vld;

    logic [ADDR_W-1:0] w_step;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W:0]   w_push_word;
    logic              w_push;
    logic              w_pop;
    logic [2:0]        w_used;
    logic              w_issue;
    logic              w_drained;

`ifdef MEMORY_READER_STRIDE_EN
    logic [ADDR_W-1:0] r_stride;
    assign w_step = r_stride;
`else
    assign w_step = ADDR_W'(1);
`endif

    assign w_rdata     = r_bank ? read_data_b : read_data_a;
    assign w_push      = r_inflight;
    assign w_push_word = {r_inflight_last, w_rdata};
    assign w_pop       = r_head_vld & strm.out_ready;
    assign w_used      = 3'(r_head_vld) + 3'(r_tail_vld) + 3'(r_inflight);
    // A word leaving this cycle frees a slot for a read issued this cycle
    assign w_issue     = (r_state == c_S_RUN) && (r_remaining != '0) &&
                         (w_used < (3'd2 + 3'(w_pop)));
    assign w_drained   = !r_inflight && !r_tail_vld && (!r_head_vld || w_pop);

    // read_addr holds the address the memory captures this cycle; an issue
    // marks that capture as wanted and advances to the next address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_S_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_bank          <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
`ifdef MEMORY_READER_STRIDE_EN
            r_stride        <= '0;
`endif
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == LEN_W'(1));
            if (w_issue) begin
                r_addr      <= r_addr + w_step;
                r_remaining <= r_remaining - LEN_W'(1);
            end
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            r_bank      <= bank_sel;
                            r_addr      <= base_addr;
                            r_remaining <= length;
`ifdef MEMORY_READER_STRIDE_EN
                            r_stride    <= stride;
`endif
                            r_busy      <= 1'b1;
                            r_state     <= c_S_RUN;
                        end else begin
                            r_done      <= 1'b1;
                            r_state     <= c_S_DONE;
                        end
                    end
                end
                c_S_RUN: begin
                    if (r_remaining == '0) begin
                        r_state <= c_S_DRAIN;
                    end
                end
                c_S_DRAIN: begin
                    if (w_drained) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_S_DONE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_head_vld <= 1'b0;
            r_tail_vld <= 1'b0;
        end else if (w_pop) begin
            if (r_tail_vld) begin
                r_head     <= r_tail;
                r_tail     <= w_push_word;
                r_tail_vld <= w_push;
            end else if (w_push) begin
                r_head     <= w_push_word;
            end else begin
                r_head_vld <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_head_vld) begin
                r_head     <= w_push_word;
                r_head_vld <= 1'b1;
            end else begin
                r_tail     <= w_push_word;
                r_tail_vld <= 1'b1;
            end
        end
    end

    assign read_addr_a    = r_addr;
    assign read_addr_b    = r_addr;
    assign strm.out_data  = r_head[DATA_W-1:0];
    assign strm.out_valid = r_head_vld;
    assign strm.out_last  = r_head_vld & r_head[DATA_W];
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

`default_nettype wire

// File: tb/tb_memory_reader.sv
// ============================================================================
// Module      : tb_memory_reader
// Description : Directed self-checking bench for memory_reader with a
//               registered-read dual-bank memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_reader;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 18;
    localparam int c_LEN_W  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                bank_sel;
    logic [c_ADDR_W-1:0] base_addr;
    logic [c_LEN_W-1:0]  length;
    logic [c_ADDR_W-1:0] stride;
    logic [c_ADDR_W-1:0] read_addr_a;
    logic [c_ADDR_W-1:0] read_addr_b;
    logic [c_DATA_W-1:0] read_data_a;
    logic [c_DATA_W-1:0] read_data_b;
    logic                busy;
    logic                done;

    int total = 0;
    int bad   = 0;

    memory_reader_if #(.DATA_W(c_DATA_W)) sif ();

    memory_reader #(
        .ADDR_W(c_ADDR_W),
        .DATA_W(c_DATA_W),
        .LEN_W (c_LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bank_sel   (bank_sel),
        .base_addr  (base_addr),
        .length     (length),
`ifdef MEMORY_READER_STRIDE_EN
        .stride     (stride),
`endif
        .read_addr_a(read_addr_a),
        .read_data_a(read_data_a),
        .read_addr_b(read_addr_b),
        .read_data_b(read_data_b),
        .strm       (sif.master),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Bank A word = its address, bank B word = address * 10
    always @(posedge clk) begin
        read_data_a <= c_DATA_W'(read_addr_a);
        read_data_b <= c_DATA_W'(32'(read_addr_b) * 10);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns in cycle 1 (start was high during cycle 0)
    task automatic issue_start(input logic bank, input logic [15:0] base,
                               input logic [15:0] len, input logic [15:0] strd);
        tick;
        start     = 1'b1;
        bank_sel  = bank;
        base_addr = base;
        length    = len;
        stride    = strd;
        tick;
        start     = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        total++;
        if ({sif.out_valid, sif.out_last, busy, done} !== 4'b0 ||
            sif.out_data !== '0 || read_addr_a !== '0 || read_addr_b !== '0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%0b last=%0b busy=%0b done=%0b data=%0h addr=%0h/%0h exp all zero",
                     sif.out_valid, sif.out_last, busy, done, sif.out_data, read_addr_a, read_addr_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream_bank_a;
        sif.out_ready = 1'b1;
        issue_start(1'b0, 16'd0, 16'd10, 16'd1);
        total++;
        if (read_addr_a !== 16'd0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_cycle1 got addr=%0h busy=%0b exp addr=0 busy=1", read_addr_a, busy);
        end
        for (int c = 2; c <= 14; c++) begin
            logic exp_valid;
            tick;
            exp_valid = (c >= 3 && c <= 12);
            total++;
            if (sif.out_valid !== exp_valid) begin
                bad++;
                $display("FAIL basic_valid c=%0d got=%0b exp=%0b", c, sif.out_valid, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if (sif.out_data !== c_DATA_W'(c - 3) || sif.out_last !== (c == 12)) begin
                    bad++;
                    $display("FAIL basic_word c=%0d got data=%0d last=%0b exp data=%0d last=%0b",
                             c, sif.out_data, sif.out_last, c - 3, (c == 12));
                end
            end
            total++;
            if (done !== (c == 13) || busy !== (c <= 12)) begin
                bad++;
                $display("FAIL basic_status c=%0d got done=%0b busy=%0b exp done=%0b busy=%0b",
                         c, done, busy, (c == 13), (c <= 12));
            end
        end
    endtask

    task automatic test_backpressure;
        logic [17:0] exp_words [4];
        int          idx = 0;
        logic        seen_done = 1'b0;
        logic        prev_hold = 1'b0;
        logic [17:0] prev_data = '0;
        exp_words[0] = 18'd20;
        exp_words[1] = 18'd30;
        exp_words[2] = 18'd40;
        exp_words[3] = 18'd50;
        sif.out_ready = 1'b0;
        issue_start(1'b1, 16'd2, 16'd4, 16'd1);
        for (int c = 1; c <= 40 && !seen_done; c++) begin
            if (c > 1) tick;
            sif.out_ready = c[0];
            if (prev_hold) begin
                total++;
                if (sif.out_valid !== 1'b1 || sif.out_data !== prev_data) begin
                    bad++;
                    $display("FAIL bp_hold c=%0d got valid=%0b data=%0d exp valid=1 data=%0d",
                             c, sif.out_valid, sif.out_data, prev_data);
                end
            end
            if (sif.out_valid === 1'b1 && sif.out_ready) begin
                total++;
                if (idx > 3 || sif.out_data !== exp_words[idx & 3] || sif.out_last !== (idx == 3)) begin
                    bad++;
                    $display("FAIL bp_word idx=%0d got data=%0d last=%0b exp data=%0d last=%0b",
                             idx, sif.out_data, sif.out_last, exp_words[idx & 3], (idx == 3));
                end
                idx++;
            end
            prev_hold = (sif.out_valid === 1'b1) && !sif.out_ready;
            prev_data = sif.out_data;
            if (done === 1'b1) seen_done = 1'b1;
        end
        total++;
        if (idx != 4 || !seen_done) begin
            bad++;
            $display("FAIL bp_count got words=%0d done_seen=%0b exp words=4 done_seen=1", idx, seen_done);
        end
        sif.out_ready = 1'b1;
    endtask

    task automatic test_zero_length;
        logic [15:0] addr_before;
        addr_before = read_addr_a;
        issue_start(1'b0, 16'h0055, 16'd0, 16'd1);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || sif.out_valid !== 1'b0 || read_addr_a !== addr_before) begin
            bad++;
            $display("FAIL zero_cycle1 got done=%0b busy=%0b valid=%0b addr=%0h exp done=1 busy=0 valid=0 addr=%0h",
                     done, busy, sif.out_valid, read_addr_a, addr_before);
        end
        tick;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || sif.out_valid !== 1'b0 || read_addr_a !== addr_before) begin
            bad++;
            $display("FAIL zero_cycle2 got done=%0b busy=%0b valid=%0b addr=%0h exp done=0 busy=0 valid=0 addr=%0h",
                     done, busy, sif.out_valid, read_addr_a, addr_before);
        end
    endtask

    task automatic test_addr_wrap;
        logic [15:0] exp_addr [4];
        exp_addr[0] = 16'hFFFE;
        exp_addr[1] = 16'hFFFF;
        exp_addr[2] = 16'h0000;
        exp_addr[3] = 16'h0001;
        sif.out_ready = 1'b1;
        issue_start(1'b0, 16'hFFFE, 16'd4, 16'd1);
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) tick;
            if (c <= 4) begin
                total++;
                if (read_addr_a !== exp_addr[c-1] || read_addr_b !== exp_addr[c-1]) begin
                    bad++;
                    $display("FAIL wrap_addr c=%0d got a=%0h b=%0h exp=%0h", c, read_addr_a, read_addr_b, exp_addr[c-1]);
                end
            end
            if (c >= 3 && c <= 6) begin
                total++;
                if (sif.out_valid !== 1'b1 || sif.out_data !== {2'b00, exp_addr[c-3]} || sif.out_last !== (c == 6)) begin
                    bad++;
                    $display("FAIL wrap_word c=%0d got valid=%0b data=%0h last=%0b exp data=%0h last=%0b",
                             c, sif.out_valid, sif.out_data, sif.out_last, exp_addr[c-3], (c == 6));
                end
            end
            if (c == 7) begin
                total++;
                if (done !== 1'b1) begin
                    bad++;
                    $display("FAIL wrap_done got=%0b exp=1", done);
                end
            end
        end
    endtask

    task automatic test_reset_mid_transfer;
        sif.out_ready = 1'b1;
        issue_start(1'b0, 16'd0, 16'd10, 16'd1);
        for (int c = 2; c <= 8; c++) tick;
        total++;
        if (sif.out_valid !== 1'b1 || sif.out_data !== 18'd5) begin
            bad++;
            $display("FAIL rstmid_word5 got valid=%0b data=%0d exp valid=1 data=5", sif.out_valid, sif.out_data);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({sif.out_valid, sif.out_last, busy, done} !== 4'b0 || sif.out_data !== '0 || read_addr_a !== '0) begin
            bad++;
            $display("FAIL rstmid_async got valid=%0b last=%0b busy=%0b done=%0b data=%0h addr=%0h exp all zero",
                     sif.out_valid, sif.out_last, busy, done, sif.out_data, read_addr_a);
        end
        tick;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            total++;
            if (done !== 1'b0 || sif.out_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_quiet k=%0d got done=%0b valid=%0b busy=%0b exp 0 0 0",
                         c, done, sif.out_valid, busy);
            end
        end
        issue_start(1'b0, 16'h0020, 16'd2, 16'd1);
        for (int c = 2; c <= 5; c++) begin
            tick;
            if (c == 3 || c == 4) begin
                total++;
                if (sif.out_valid !== 1'b1 || sif.out_data !== c_DATA_W'(32'h1D + c) || sif.out_last !== (c == 4)) begin
                    bad++;
                    $display("FAIL rstmid_restart c=%0d got valid=%0b data=%0h last=%0b exp data=%0h last=%0b",
                             c, sif.out_valid, sif.out_data, sif.out_last, 32'h1D + c, (c == 4));
                end
            end
            if (c == 5) begin
                total++;
                if (done !== 1'b1) begin
                    bad++;
                    $display("FAIL rstmid_done got=%0b exp=1", done);
                end
            end
        end
    endtask

`ifdef MEMORY_READER_STRIDE_EN
    task automatic test_stride;
        logic [17:0] exp_s [3];
        exp_s[0] = 18'd1;
        exp_s[1] = 18'd4;
        exp_s[2] = 18'd7;
        sif.out_ready = 1'b1;
        issue_start(1'b0, 16'd1, 16'd3, 16'd3);
        for (int c = 2; c <= 6; c++) begin
            tick;
            if (c >= 3 && c <= 5) begin
                total++;
                if (sif.out_valid !== 1'b1 || sif.out_data !== exp_s[c-3] || sif.out_last !== (c == 5)) begin
                    bad++;
                    $display("FAIL stride3 c=%0d got data=%0d last=%0b exp data=%0d last=%0b",
                             c, sif.out_data, sif.out_last, exp_s[c-3], (c == 5));
                end
            end
        end
        issue_start(1'b0, 16'd1, 16'd3, 16'd0);
        for (int c = 2; c <= 6; c++) begin
            tick;
            if (c >= 3 && c <= 5) begin
                total++;
                if (sif.out_valid !== 1'b1 || sif.out_data !== 18'd1 || sif.out_last !== (c == 5)) begin
                    bad++;
                    $display("FAIL stride0 c=%0d got data=%0d last=%0b exp data=1 last=%0b",
                             c, sif.out_data, sif.out_last, (c == 5));
                end
            end
        end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        bank_sel      = 1'b0;
        base_addr     = '0;
        length        = '0;
        stride        = 16'd1;
        sif.out_ready = 1'b1;
        test_reset;
        test_stream_bank_a;
        test_backpressure;
        test_zero_length;
        test_addr_wrap;
        test_reset_mid_transfer;
`ifdef MEMORY_READER_STRIDE_EN
        test_stride;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_reader.md
Name: memory_reader

Overview:
- Read-side initiator for the dual-bank image memory. On a start command it sweeps a contiguous address range in bank A or bank B.
- Absorbs the memory's 1-cycle registered read latency and presents the words as a valid/ready stream with a last marker.
- Sits between the image memory and downstream consumers (filter / systolic feed). Holds full throughput under backpressure using a 2-entry skid FIFO and credit-based read issue.

Parameters:
- ADDR_W, 16, width of the memory word address driven on both read address ports. The integrator zero-extends it to the bank A port width.
- DATA_W, 18, memory word width and stream data width.
- LEN_W, 16, width of the transfer length field, in words.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  command strobe; sampled only while busy=0
- bank_sel  in  1  0 = bank A (port a), 1 = bank B (port b); latched on start
- base_addr  in  ADDR_W  first word address; latched on start
- length  in  LEN_W  number of words to read; latched on start
- read_addr_a  out  ADDR_W  bank A read address
- read_data_a  in  DATA_W  bank A read data, valid 1 cycle after address
- read_addr_b  out  ADDR_W  bank B read address
- read_data_b  in  DATA_W  bank B read data, valid 1 cycle after address
- out_data  out  DATA_W  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from consumer
- out_last  out  1  marks the final word of the transfer
- busy  out  1  high from the start-accept edge until the final word is consumed
- done  out  1  one-cycle pulse after the final word is consumed (or for a zero-length start)

Behaviour:
- Reset (async): state=IDLE; read_addr_a/b=0; out_valid=0; out_last=0; out_data=0; busy=0; done=0; FIFO emptied; in-flight flag cleared. Reset mid-transfer abandons the transfer; no done pulse.
- FSM states:
  - IDLE: start=1 with length!=0 latches bank_sel, base_addr and length, and sets remaining=length, next_addr=base_addr. Goes to RUN, busy=1 next cycle.
  - IDLE: start=1 with length=0 goes to DONE (done pulses next cycle, busy stays 0). No read is issued and no stream word is produced.
  - RUN: issues reads until remaining=0, then goes to DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is in flight, then goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, returns to IDLE.
- start while busy=1 is ignored.
- Read issue:
  - Both read_addr_a and read_addr_b are driven with the same registered address. Data is taken from the latched bank's read_data port.
  - Credit = 2 - fifo_count - inflight + (out_valid & out_ready). A read is issued in a cycle only if credit > 0 and remaining > 0.
  - On issue: next_addr increments by 1 modulo 2^ADDR_W (wraps at the top of the space), remaining decrements, inflight=1 for the following cycle.
  - Data returning for an in-flight read is pushed into the FIFO that cycle. The FIFO never overflows.
- Stream side:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - A word is held stable while out_valid=1 and out_ready=0.
  - Pop occurs on out_valid & out_ready. Simultaneous push and pop in one cycle is supported.
  - out_last=1 with the word whose index is length-1. length=1 gives a single word with out_last=1.
- Latency: start high in cycle 0 → address=base in cycle 1 → memory data in cycle 2 → out_valid=1 in cycle 3.
- Throughput: with out_ready held high, one word per cycle, so length N completes with done in cycle N+3.

Optional Feature:
- Macro: MEMORY_READER_STRIDE_EN.
- Defined: adds port stride (in, ADDR_W), latched on start. Address advances by stride modulo 2^ADDR_W, giving column and subsampled reads. stride=0 re-reads base_addr length times.
- Undefined: port absent; increment fixed at 1.

Test Plan:
- Bank A, base=0, length=10, out_ready=1 → out_data 0..9 in cycles 3..12; out_last on word 9; done pulse in cycle 13; busy 1→0.
- Bank B, base=2, length=4, out_ready toggling 1,0,1,0 → words 20,30,40,50 in order, each held while ready=0. No word lost or duplicated; FIFO never exceeds 2 entries.
- length=0 → no out_valid, no read address change, done pulse 1 cycle after start, busy stays 0.
- base=0xFFFE, length=4 → addresses FFFE, FFFF, 0000, 0001 issued; out_last on 4th word.
- Assert rst during word 5 of a length-10 transfer → all outputs 0 immediately, no done pulse; new start with length=2 afterwards completes normally.
- MEMORY_READER_STRIDE_EN defined, bank A, base=1, stride=3, length=3 → words 1, 4, 7; stride=0, length=3 → 1, 1, 1.
